// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake; the
// operand path is cut into STAGES slices. Define CLA_PIPE_FLAGS_EN for V/Z flags.
module cla_pipe_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             V,
  output logic             Z
);

  localparam int SW = WIDTH / STAGES;
  localparam int NG = SW / 4;

  if ((WIDTH % (4 * STAGES)) != 0 || WIDTH < 4 || WIDTH > 64 ||
      STAGES < 1 || STAGES > 4) begin : g_bad_cfg
    $error("cla_pipe_addsub: illegal WIDTH/STAGES combination");
  end

  // One beat as it travels down the pipe: effective operands, the sum bits
  // resolved so far, and the carry into the next slice.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
  } beat_t;

  // Returns {carry_out, sum} of one slice built from 4-bit lookahead groups.
  function automatic logic [SW:0] cla_slice(input logic [SW-1:0] a,
                                            input logic [SW-1:0] b,
                                            input logic          cin);
    logic [SW-1:0] sum;
    logic [SW:0]   c;
    logic [3:0]    p4, g4;
    logic          grp_g, grp_p;
    c = '0;
    sum = '0;
    c[0] = cin;
    for (int j = 0; j < NG; j++) begin
      p4 = a[4*j +: 4] ^ b[4*j +: 4];
      g4 = a[4*j +: 4] & b[4*j +: 4];
      c[4*j+1] = g4[0] | (p4[0] & c[4*j]);
      c[4*j+2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & c[4*j]);
      c[4*j+3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0]) |
                 (p4[2] & p4[1] & p4[0] & c[4*j]);
      grp_g = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1]) |
              (p4[3] & p4[2] & p4[1] & g4[0]);
      grp_p = &p4;
      c[4*j+4] = grp_g | (grp_p & c[4*j]);
      sum[4*j +: 4] = p4 ^ c[4*j +: 4];
    end
    return {c[SW], sum};
  endfunction

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    beat_t       src, nxt, q;
    logic        vld_src, vld_q;
    logic [SW:0] res;

    if (k == 0) begin : g_first
      always_comb begin
        src.a   = A;
        src.b   = Sub ? ~B : B;
        src.s   = '0;
        src.c   = Sub | Ci;
        vld_src = in_valid;
      end
    end else begin : g_next
      assign src     = g_stage[k-1].q;
      assign vld_src = g_stage[k-1].vld_q;
    end

    // NOTE: combinational blocks use blocking '=' so later statements see the
    // value just computed; the registers below use '<=' exclusively.
    always_comb begin
      res                 = cla_slice(src.a[k*SW +: SW], src.b[k*SW +: SW], src.c);
      nxt                 = src;
      nxt.s[k*SW +: SW]   = res[SW-1:0];
      nxt.c               = res[SW];
    end

    // NOTE: only valid bits and the visible result are reset; the operand and
    // partial-sum registers are qualified by valid, so clearing them buys nothing.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        if (k == STAGES - 1) begin
          q.s <= '0;
          q.c <= 1'b0;
        end
      end else if (adv) begin
        vld_q <= vld_src;
        q     <= nxt;
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].vld_q;
  assign S         = g_stage[STAGES-1].q.s;
  assign Co        = g_stage[STAGES-1].q.c;

`ifdef CLA_PIPE_FLAGS_EN
  beat_t last_nxt;
  logic  v_q, z_q;
  assign last_nxt = g_stage[STAGES-1].nxt;

  // Carry into the MSB is recovered as a^b^s at that bit position.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 1'b0;
      z_q <= 1'b0;
    end else if (adv) begin
      v_q <= last_nxt.a[WIDTH-1] ^ last_nxt.b[WIDTH-1] ^ last_nxt.s[WIDTH-1] ^ last_nxt.c;
      z_q <= (last_nxt.s == '0);
    end
  end

  assign V = v_q;
  assign Z = z_q;
`else
  assign V = 1'b0;
  assign Z = 1'b0;
`endif

endmodule
